fifo_checker: RTL and testbench

- Synthesizable passive checker that sits on the read/observe side of the sync FIFO interface, opposite the stimulus driver.
- Samples the same wr_en/rd_en/data_in stream the driver applies, keeps its own reference occupancy model, and compares it against the DUT's outputs every cycle.
- Reports mismatches, keeps pass/error counters, and raises a done/summary indication when the test-finished flag arrives.

---
 rtl/shared_pkg.sv | 26 ++
 rtl/fifo_ref_model.sv | 80 ++++++++
 rtl/fifo_checker.sv | 131 +++++++++++++
 tb/tb_fifo_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared types and defaults for the sync FIFO checker.
package shared_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 16;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_ARM,
    ST_CHECK,
    ST_HALT,
    ST_DONE
  } chk_state_e;

  // Bit positions inside err_code.
  typedef enum logic [2:0] {
    DOUT   = 3'd0,
    FULL   = 3'd1,
    EMPTY  = 3'd2,
    WRACK  = 3'd3,
    OVF    = 3'd4,
    UDF    = 3'd5,
    AFULL  = 3'd6,
    AEMPTY = 3'd7
  } chk_err_e;

endpackage

// File: rtl/fifo_ref_model.sv
// Reference occupancy model of the sync FIFO: storage, pointers, count and the
// expected values of the DUT's registered outputs.
module fifo_ref_model
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [OCC_W-1:0]      count,
  output logic [FIFO_WIDTH-1:0] exp_dout,
  output logic                  exp_wr_ack,
  output logic                  exp_ovf,
  output logic                  exp_udf
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] exp_dout_q;
  logic                  exp_wr_ack_q, exp_ovf_q, exp_udf_q;
  logic                  full_m, empty_m, wr_ok, rd_ok;

  assign full_m  = (count_q == DEPTH_C);
  assign empty_m = (count_q == '0);
  // Full gates the write and empty gates the read, so a simultaneous pair at
  // either boundary degenerates to the single legal operation.
  assign wr_ok   = wr_en & ~full_m;
  assign rd_ok   = rd_en & ~empty_m;

  always_comb begin
    count_d = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      exp_dout_q   <= '0;
      exp_wr_ack_q <= 1'b0;
      exp_ovf_q    <= 1'b0;
      exp_udf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        exp_dout_q <= mem[rd_ptr_q];
      end
      count_q      <= count_d;
      exp_wr_ack_q <= wr_ok;
      exp_ovf_q    <= wr_en & full_m;
      exp_udf_q    <= rd_en & empty_m;
    end
  end

  assign count      = count_q;
  assign exp_dout   = exp_dout_q;
  assign exp_wr_ack = exp_wr_ack_q;
  assign exp_ovf    = exp_ovf_q;
  assign exp_udf    = exp_udf_q;

endmodule

// File: rtl/fifo_checker.sv
// Passive sync-FIFO checker: reference model, per-cycle compare, counters, FSM.
// Define FIFO_CHK_ALMOST_EN to also check the almost-full/almost-empty flags.
module fifo_checker
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mon_wr_en,
  input  logic                  mon_rd_en,
  input  logic [FIFO_WIDTH-1:0] mon_data_in,
  input  logic [FIFO_WIDTH-1:0] mon_data_out,
  input  logic                  mon_full,
  input  logic                  mon_empty,
  input  logic                  mon_wr_ack,
  input  logic                  mon_overflow,
  input  logic                  mon_underflow,
`ifdef FIFO_CHK_ALMOST_EN
  input  logic                  mon_almostfull,
  input  logic                  mon_almostempty,
`endif
  input  logic                  test_finished,
  input  logic                  stop_on_err,
  output logic                  err_pulse,
  output logic [7:0]            err_code,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      pass_count,
  output logic                  done,
  output logic                  pass
);

  localparam int unsigned     OCC_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  chk_state_e            state_q, state_d;
  logic [OCC_W-1:0]      count;
  logic [FIFO_WIDTH-1:0] exp_dout;
  logic                  exp_wr_ack, exp_ovf, exp_udf;
  logic [7:0]            err_vec;
  logic                  mismatch, check_en;
  logic                  err_pulse_q;
  logic [7:0]            err_code_q;
  logic [CNT_W-1:0]      err_count_q, err_count_d, pass_count_q, pass_count_d;

  fifo_ref_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ref_model (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (mon_wr_en),
    .rd_en      (mon_rd_en),
    .data_in    (mon_data_in),
    .count      (count),
    .exp_dout   (exp_dout),
    .exp_wr_ack (exp_wr_ack),
    .exp_ovf    (exp_ovf),
    .exp_udf    (exp_udf)
  );

  // Flags are checked against the model state before this edge's update.
  always_comb begin
    err_vec         = '0;
    err_vec[DOUT]   = (mon_data_out != exp_dout);
    err_vec[FULL]   = (mon_full != (count == DEPTH_C));
    err_vec[EMPTY]  = (mon_empty != (count == '0));
    err_vec[WRACK]  = (mon_wr_ack != exp_wr_ack);
    err_vec[OVF]    = (mon_overflow != exp_ovf);
    err_vec[UDF]    = (mon_underflow != exp_udf);
`ifdef FIFO_CHK_ALMOST_EN
    err_vec[AFULL]  = (mon_almostfull != (count == DEPTH_C - OCC_W'(1)));
    err_vec[AEMPTY] = (mon_almostempty != (count == OCC_W'(1)));
`endif
  end

  assign mismatch = |err_vec;
  assign check_en = (state_q == ST_CHECK);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARM:   state_d = ST_CHECK;
      ST_CHECK: begin
        if (test_finished)                state_d = ST_DONE;
        else if (mismatch && stop_on_err) state_d = ST_HALT;
      end
      ST_HALT:  if (test_finished) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_ARM;
    endcase
  end

  always_comb begin
    err_count_d  = err_count_q;
    pass_count_d = pass_count_q;
    if (check_en) begin
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      end else if (pass_count_q != '1) begin
        pass_count_d = pass_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARM;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
      err_count_q  <= '0;
      pass_count_q <= '0;
    end else begin
      state_q      <= state_d;
      err_pulse_q  <= check_en & mismatch;
      err_code_q   <= check_en ? err_vec : 8'h00;
      err_count_q  <= err_count_d;
      pass_count_q <= pass_count_d;
    end
  end

  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_count  = err_count_q;
  assign pass_count = pass_count_q;
  assign done       = (state_q == ST_DONE);
  assign pass       = done & (err_count_q == '0);

endmodule

// File: tb/tb_fifo_checker.sv
// Directed testbench for fifo_checker: the bench plays the observed FIFO by hand.
module tb_fifo_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_wr_en = 1'b0, mon_rd_en = 1'b0;
  logic [15:0] mon_data_in = '0, mon_data_out = '0;
  logic        mon_full = 1'b0, mon_empty = 1'b1;
  logic        mon_wr_ack = 1'b0, mon_overflow = 1'b0, mon_underflow = 1'b0;
`ifdef FIFO_CHK_ALMOST_EN
  logic        mon_almostfull = 1'b0, mon_almostempty = 1'b0;
`endif
  logic        test_finished = 1'b0, stop_on_err = 1'b0;
  logic        err_pulse, done, pass;
  logic [7:0]  err_code;
  logic [15:0] err_count, pass_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_checker dut (
    .clk           (clk),
    .rst           (rst),
    .mon_wr_en     (mon_wr_en),
    .mon_rd_en     (mon_rd_en),
    .mon_data_in   (mon_data_in),
    .mon_data_out  (mon_data_out),
    .mon_full      (mon_full),
    .mon_empty     (mon_empty),
    .mon_wr_ack    (mon_wr_ack),
    .mon_overflow  (mon_overflow),
    .mon_underflow (mon_underflow),
`ifdef FIFO_CHK_ALMOST_EN
    .mon_almostfull  (mon_almostfull),
    .mon_almostempty (mon_almostempty),
`endif
    .test_finished (test_finished),
    .stop_on_err   (stop_on_err),
    .err_pulse     (err_pulse),
    .err_code      (err_code),
    .err_count     (err_count),
    .pass_count    (pass_count),
    .done          (done),
    .pass          (pass)
  );

  // One observed cycle: new ops plus what the FIFO presents during that cycle.
  task automatic set_vec(input logic wr, input logic rd, input logic [15:0] din,
                         input logic [15:0] dout, input logic full, input logic empty,
                         input logic ack, input logic ovf, input logic udf);
    mon_wr_en     = wr;
    mon_rd_en     = rd;
    mon_data_in   = din;
    mon_data_out  = dout;
    mon_full      = full;
    mon_empty     = empty;
    mon_wr_ack    = ack;
    mon_overflow  = ovf;
    mon_underflow = udf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_vec(0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    vectors++; if (err_pulse !== 1'b0) begin miscompares++;
      $display("FAIL rst_err_pulse: got %b want 0", err_pulse); end
    vectors++; if (err_code !== 8'h00) begin miscompares++;
      $display("FAIL rst_err_code: got %h want 00", err_code); end
    vectors++; if (err_count !== 16'd0) begin miscompares++;
      $display("FAIL rst_err_count: got %0d want 0", err_count); end
    vectors++; if (pass_count !== 16'd0) begin miscompares++;
      $display("FAIL rst_pass_count: got %0d want 0", pass_count); end
    vectors++; if ({done, pass} !== 2'b00) begin miscompares++;
      $display("FAIL rst_done_pass: got %b want 00", {done, pass}); end
  endtask

  task automatic test_fill();
    do_reset();
    set_vec(0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0);
    tick();
    vectors++; if (pass_count !== 16'd0) begin miscompares++;
      $display("FAIL arm_no_compare: got pass_count %0d want 0", pass_count); end
    for (int i = 0; i < 8; i++) begin
      set_vec(1, 0, 16'(i + 1), 16'h0, 0, (i == 0), (i > 0), 0, 0);
      tick();
    end
    set_vec(0, 0, 16'h0, 16'h0, 1, 0, 1, 0, 0);
    tick();
    vectors++; if (err_count !== 16'd0) begin miscompares++;
      $display("FAIL fill_err_count: got %0d want 0", err_count); end
    vectors++; if (pass_count !== 16'd9) begin miscompares++;
      $display("FAIL fill_pass_count: got %0d want 9", pass_count); end
  endtask

  task automatic test_overflow();
    set_vec(1, 0, 16'h0009, 16'h0, 1, 0, 0, 0, 0);
    tick();
    vectors++; if (err_pulse !== 1'b0) begin miscompares++;
      $display("FAIL ovf_write_clean: got err_pulse %b want 0", err_pulse); end
    // Faulty FIFO: overflow stays low after the rejected write.
    set_vec(0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0);
    tick();
    vectors++; if (err_pulse !== 1'b1) begin miscompares++;
      $display("FAIL ovf_pulse: got %b want 1", err_pulse); end
    vectors++; if (err_code !== 8'h10) begin miscompares++;
      $display("FAIL ovf_code: got %h want 10", err_code); end
    vectors++; if (err_count !== 16'd1) begin miscompares++;
      $display("FAIL ovf_err_count: got %0d want 1", err_count); end
    set_vec(0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0);
    tick();
    vectors++; if ({err_pulse, err_code} !== 9'h000) begin miscompares++;
      $display("FAIL ovf_clears: got %b/%h want 0/00", err_pulse, err_code); end
  endtask

  task automatic test_simul_full();
    // Write is refused while full, read of the oldest entry proceeds.
    set_vec(1, 1, 16'hAAAA, 16'h0, 1, 0, 0, 0, 0);
    tick();
    set_vec(0, 0, 16'h0, 16'h0001, 0, 0, 0, 1, 0);
    tick();
    vectors++; if (err_pulse !== 1'b0) begin miscompares++;
      $display("FAIL simul_clean: got err_pulse %b code %h want 0", err_pulse, err_code); end
    vectors++; if (err_count !== 16'd1) begin miscompares++;
      $display("FAIL simul_err_count: got %0d want 1", err_count); end
    vectors++; if (pass_count !== 16'd13) begin miscompares++;
      $display("FAIL simul_pass_count: got %0d want 13", pass_count); end
  endtask

  task automatic test_mid_reset();
    // Model holds 7 entries; claiming full twice raises the count to 3.
    repeat (2) begin
      set_vec(0, 0, 16'h0, 16'h0001, 1, 0, 0, 0, 0);
      tick();
    end
    vectors++; if (err_code !== 8'h02) begin miscompares++;
      $display("FAIL full_code: got %h want 02", err_code); end
    vectors++; if (err_count !== 16'd3) begin miscompares++;
      $display("FAIL pre_reset_err_count: got %0d want 3", err_count); end
    rst = 1'b1;
    #1;
    vectors++; if ({err_pulse, err_code, err_count, pass_count, done, pass} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %b %h %0d %0d %b %b want all 0",
               err_pulse, err_code, err_count, pass_count, done, pass);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_vec(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    tick();
    vectors++; if ({err_pulse, err_count} !== 17'h0) begin miscompares++;
      $display("FAIL arm_after_reset: got %b/%0d want 0/0", err_pulse, err_count); end
    tick();
    vectors++; if ({err_pulse, err_code} !== 9'h104) begin miscompares++;
      $display("FAIL first_compare: got %b/%h want 1/04", err_pulse, err_code); end
  endtask

  task automatic test_underflow_dout();
    do_reset();
    tick();
    set_vec(0, 1, 16'h0, 16'h0, 0, 1, 0, 0, 0);
    tick();
    set_vec(1, 0, 16'h0001, 16'h0, 0, 1, 0, 0, 1);
    tick();
    vectors++; if (err_pulse !== 1'b0) begin miscompares++;
      $display("FAIL udf_match: got err_pulse %b code %h want 0", err_pulse, err_code); end
    set_vec(0, 1, 16'h0, 16'h0, 0, 0, 1, 0, 0);
    tick();
    set_vec(0, 0, 16'h0, 16'hDEAD, 0, 1, 0, 0, 0);
    tick();
    vectors++; if ({err_pulse, err_code} !== 9'h101) begin miscompares++;
      $display("FAIL dout_code: got %b/%h want 1/01", err_pulse, err_code); end
    vectors++; if (pass_count !== 16'd3) begin miscompares++;
      $display("FAIL dout_pass_count: got %0d want 3", pass_count); end
  endtask

  task automatic test_stop_on_err();
    stop_on_err = 1'b1;
    do_reset();
    tick();
    set_vec(0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    tick();
    vectors++; if ({err_pulse, err_code, err_count} !== {1'b1, 8'h04, 16'd1}) begin
      miscompares++;
      $display("FAIL halt_first_err: got %b/%h/%0d want 1/04/1", err_pulse, err_code, err_count);
    end
    tick();
    vectors++; if ({err_pulse, err_count} !== {1'b0, 16'd1}) begin miscompares++;
      $display("FAIL halt_frozen: got %b/%0d want 0/1", err_pulse, err_count); end
    test_finished = 1'b1;
    tick();
    vectors++; if ({done, pass} !== 2'b10) begin miscompares++;
      $display("FAIL halt_done: got done %b pass %b want 1 0", done, pass); end
    test_finished = 1'b0;
    stop_on_err   = 1'b0;
  endtask

  task automatic test_done_pass();
    do_reset();
    tick();
    test_finished = 1'b1;
    tick();
    vectors++; if ({done, pass, pass_count} !== {2'b11, 16'd1}) begin miscompares++;
      $display("FAIL clean_done: got %b %b %0d want 1 1 1", done, pass, pass_count); end
    test_finished = 1'b0;
    set_vec(0, 0, 16'h0, 16'h0, 1, 0, 0, 0, 0);
    tick();
    vectors++; if ({done, pass, err_count} !== {2'b11, 16'd0}) begin miscompares++;
      $display("FAIL done_terminal: got %b %b %0d want 1 1 0", done, pass, err_count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_simul_full();
    test_mid_reset();
    test_underflow_dout();
    test_stop_on_err();
    test_done_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
